// File: rtl/lif_neuron_seq_pkg.sv
// Shared constants and types for the serial LIF neuron core.
// Q8.16 fixed point throughout: 1.0 == 65536.
// Arithmetic is carried in CALC_W bits so sum terms never wrap before saturation.
package lif_neuron_seq_pkg;
  localparam int N_NEURON       = 18;
  localparam int V_W            = 25;
  localparam int IDX_W          = 5;
  localparam int CALC_W         = 27;

  localparam int ONE            = 65536;
  localparam int V_TH_DEF       = 1310720;
  localparam int INHBT_STEP     = 458752;
  localparam int INHBT_MAX      = 655360;
  localparam int V_MAX          = (1 << 24) - 1;
  localparam int LEAK_SHIFT_DEF = 4;
  localparam int T_REF_DEF      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/lif_neuron_seq_if.sv
// Handshake and data bundle between the sweep controller and its environment.
// master drives the timestep request and currents; slave is the neuron core.
// All core outputs are registered inside the core.
interface lif_neuron_seq_if;
  import lif_neuron_seq_pkg::*;

  logic                       i_start;
  logic                       i_sample_start;
  logic [N_NEURON*V_W-1:0]    i_current;
  logic signed [V_W-1:0]      i_inhbt;
  logic                       o_valid;
  logic                       o_spike;
  logic [IDX_W-1:0]           o_neuron_idx;
  logic                       o_cnt_clr;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    output i_start, i_sample_start, i_current, i_inhbt,
    input  o_valid, o_spike, o_neuron_idx, o_cnt_clr, o_busy, o_done
  );

  modport slave (
    input  i_start, i_sample_start, i_current, i_inhbt,
    output o_valid, o_spike, o_neuron_idx, o_cnt_clr, o_busy, o_done
  );
endinterface

// File: rtl/lif_neuron_seq_update_unit.sv
// Combinational single-neuron LIF update: leak, integrate, inhibit, saturate, fire.
// Zero latency (pure combinational).
// No flow control; evaluated once per RUN cycle for the addressed neuron.
module lif_update_unit
  import lif_neuron_seq_pkg::*;
#(
  parameter int V_TH       = V_TH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int T_REF      = T_REF_DEF,
  parameter int REF_W      = 2
) (
  input  logic signed [V_W-1:0] v_i,
  input  logic signed [V_W-1:0] cur_i,
  input  logic signed [V_W-1:0] inh_i,
  input  logic [REF_W-1:0]      ref_i,
  output logic signed [V_W-1:0] v_next_o,
  output logic [REF_W-1:0]      ref_next_o,
  output logic                  spike_o
);
  localparam logic signed [CALC_W-1:0] SAT_HI = CALC_W'(V_MAX);
  localparam logic signed [CALC_W-1:0] TH     = CALC_W'(V_TH);

  logic signed [CALC_W-1:0] v_ext;
  logic signed [CALC_W-1:0] cur_ext;
  logic signed [CALC_W-1:0] inh_ext;
  logic signed [CALC_W-1:0] sum;
  logic signed [CALC_W-1:0] v_sat;

  // Leak/integrate in wide signed arithmetic, clamp to [0, 2^24-1], then threshold.
  always_comb begin
    v_ext      = {{(CALC_W-V_W){v_i[V_W-1]}}, v_i};
    cur_ext    = {{(CALC_W-V_W){cur_i[V_W-1]}}, cur_i};
    inh_ext    = {{(CALC_W-V_W){inh_i[V_W-1]}}, inh_i};
    sum        = v_ext - (v_ext >>> LEAK_SHIFT) + cur_ext - inh_ext;
    v_sat      = sum;
    if (sum < 0) begin
      v_sat = '0;
    end else if (sum > SAT_HI) begin
      v_sat = SAT_HI;
    end
    v_next_o   = '0;
    ref_next_o = '0;
    spike_o    = 1'b0;
    if (ref_i != '0) begin
      // Refractory: the neuron is held at rest and its input is ignored.
      ref_next_o = ref_i - 1'b1;
    end else if (v_sat >= TH) begin
      spike_o    = 1'b1;
      ref_next_o = REF_W'(T_REF);
    end else begin
      v_next_o   = v_sat[V_W-1:0];
    end
  end
endmodule

// File: rtl/lif_neuron_seq.sv
// Serial LIF core: sweeps 18 neurons one per cycle per timestep request.
// Latency: start edge -> first result 2 cycles later; 21-cycle back-to-back period.
// No backpressure: starts outside IDLE are dropped, results stream without gaps.
module lif_neuron_seq
  import lif_neuron_seq_pkg::*;
#(
  parameter int V_TH       = V_TH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int T_REF      = T_REF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  lif_neuron_seq_if.slave  bus
);
  localparam int REF_W = (T_REF < 2) ? 1 : $clog2(T_REF + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic signed [V_W-1:0] cur_q [N_NEURON];
  logic signed [V_W-1:0] inh_q;
  logic signed [V_W-1:0] v_q   [N_NEURON];
  logic [REF_W-1:0]      ref_q [N_NEURON];

  logic                  valid_q;
  logic                  spike_q;
  logic [IDX_W-1:0]      out_idx_q;
  logic                  cnt_clr_q;
  logic                  busy_q;
  logic                  done_q;

  logic signed [V_W-1:0] v_d;
  logic [REF_W-1:0]      ref_d;
  logic                  spike_d;

  lif_update_unit #(
    .V_TH       (V_TH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .T_REF      (T_REF),
    .REF_W      (REF_W)
  ) u_update (
    .v_i        (v_q[idx_q]),
    .cur_i      (cur_q[idx_q]),
    .inh_i      (inh_q),
    .ref_i      (ref_q[idx_q]),
    .v_next_o   (v_d),
    .ref_next_o (ref_d),
    .spike_o    (spike_d)
  );

  // Sweep FSM, neuron state storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      inh_q     <= '0;
      valid_q   <= 1'b0;
      spike_q   <= 1'b0;
      out_idx_q <= '0;
      cnt_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < N_NEURON; k++) begin
        cur_q[k] <= '0;
        v_q[k]   <= '0;
        ref_q[k] <= '0;
      end
    end else begin
      valid_q   <= 1'b0;
      spike_q   <= 1'b0;
      out_idx_q <= '0;
      cnt_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            // Currents and inhibition are frozen here for the whole sweep.
            for (int k = 0; k < N_NEURON; k++) begin
              cur_q[k] <= bus.i_current[k*V_W +: V_W];
              if (bus.i_sample_start) begin
                v_q[k]   <= '0;
                ref_q[k] <= '0;
              end
            end
            inh_q     <= bus.i_inhbt;
            cnt_clr_q <= bus.i_sample_start;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          v_q[idx_q]   <= v_d;
          ref_q[idx_q] <= ref_d;
          valid_q      <= 1'b1;
          spike_q      <= spike_d;
          out_idx_q    <= idx_q;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_spike      = spike_q;
  assign bus.o_neuron_idx = out_idx_q;
  assign bus.o_cnt_clr    = cnt_clr_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
endmodule

// File: tb/tb_lif_neuron_seq.sv
// Self-checking bench for lif_neuron_seq: scoreboard of per-neuron spikes plus
// handshake timing, saturation, sample-boundary and mid-sweep reset scenarios.
// Inputs driven at negedge; outputs sampled 1 time unit after posedge.
module tb_lif_neuron_seq;
  import lif_neuron_seq_pkg::*;

  typedef struct {
    int idx;
    bit spk;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  longint mv   [N_NEURON];
  int     mref [N_NEURON];
  exp_t   sbq  [$];

  lif_neuron_seq_if bif ();

  lif_neuron_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_NEURON; k++) begin
      mv[k]   = 0;
      mref[k] = 0;
    end
  endtask

  // Reference LIF behaviour; pushes the expected result for each neuron of one sweep.
  task automatic model_step(input bit smp, input logic [N_NEURON*V_W-1:0] cur,
                            input logic signed [V_W-1:0] inh);
    logic signed [V_W-1:0] ci;
    longint c;
    longint vn;
    longint inh_l;
    exp_t e;
    inh_l = inh;
    if (smp) model_reset();
    for (int k = 0; k < N_NEURON; k++) begin
      ci    = cur[k*V_W +: V_W];
      c     = ci;
      e.idx = k;
      e.spk = 1'b0;
      if (mref[k] != 0) begin
        mref[k] = mref[k] - 1;
        mv[k]   = 0;
      end else begin
        vn = mv[k] - (mv[k] >>> 4) + c - inh_l;
        if (vn < 0) vn = 0;
        if (vn > 64'sd16777215) vn = 16777215;
        if (vn >= 1310720) begin
          e.spk   = 1'b1;
          mv[k]   = 0;
          mref[k] = 2;
        end else begin
          mv[k] = vn;
        end
      end
      sbq.push_back(e);
    end
  endtask

  // One timestep: start, check handshake cycle by cycle, compare results to the scoreboard.
  task automatic run_step(input bit smp, input logic [N_NEURON*V_W-1:0] cur,
                          input logic signed [V_W-1:0] inh, input int exp_spk,
                          input int abort_at, input bit poke);
    int   seen;
    bit   any_done;
    exp_t e;
    seen = 0;
    model_step(smp, cur, inh);
    @(negedge clk);
    bif.i_start        = 1'b1;
    bif.i_sample_start = smp;
    bif.i_current      = cur;
    bif.i_inhbt        = inh;
    @(posedge clk); #1;
    bif.i_start        = 1'b0;
    bif.i_sample_start = 1'b0;
    bif.i_current      = ~cur;
    bif.i_inhbt        = 25'sd0;
    chk("cnt_clr_load", bif.o_cnt_clr, smp);
    chk("busy_load", bif.o_busy, 1);
    chk("valid_load", bif.o_valid, 0);
    @(posedge clk); #1;
    chk("cnt_clr_pulse_end", bif.o_cnt_clr, 0);
    chk("valid_before_run", bif.o_valid, 0);
    for (int k = 0; k < N_NEURON; k++) begin
      @(posedge clk); #1;
      chk("valid_run", bif.o_valid, 1);
      chk("cnt_clr_run", bif.o_cnt_clr, 0);
      chk("done_run", bif.o_done, 0);
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("neuron_idx", bif.o_neuron_idx, e.idx);
        chk($sformatf("spike_n%0d", e.idx), bif.o_spike, e.spk);
      end
      seen += int'(bif.o_spike);
      bif.i_start = (poke && (k == 5)) ? 1'b1 : 1'b0;
      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_valid", bif.o_valid, 0);
        chk("rst_spike", bif.o_spike, 0);
        chk("rst_idx", bif.o_neuron_idx, 0);
        chk("rst_busy", bif.o_busy, 0);
        chk("rst_done", bif.o_done, 0);
        chk("rst_cnt_clr", bif.o_cnt_clr, 0);
        sbq.delete();
        model_reset();
        any_done = 1'b0;
        for (int j = 0; j < 25; j++) begin
          @(posedge clk); #1;
          any_done |= bif.o_done | bif.o_valid;
        end
        chk("no_done_after_abort", any_done, 0);
        return;
      end
    end
    bif.i_start = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", bif.o_done, 1);
    chk("valid_in_done", bif.o_valid, 0);
    @(posedge clk); #1;
    chk("done_end", bif.o_done, 0);
    chk("busy_idle", bif.o_busy, 0);
    if (poke) begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        chk("no_extra_sweep", bif.o_busy | bif.o_valid, 0);
      end
    end
    chk("spike_count", seen, exp_spk);
  endtask

  initial begin
    logic [N_NEURON*V_W-1:0] cur;
    int integ_exp [7];
    n_chk  = 0;
    n_pass = 0;
    bif.i_start        = 1'b0;
    bif.i_sample_start = 1'b0;
    bif.i_current      = '0;
    bif.i_inhbt        = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("por_valid", bif.o_valid, 0);
    chk("por_spike", bif.o_spike, 0);
    chk("por_idx", bif.o_neuron_idx, 0);
    chk("por_cnt_clr", bif.o_cnt_clr, 0);
    chk("por_busy", bif.o_busy, 0);
    chk("por_done", bif.o_done, 0);

    // Integration on neuron 3 with I = 7.0: fires on step 4, refractory 5-6.
    integ_exp = '{0, 0, 0, 1, 0, 0, 0};
    cur = '0;
    cur[3*V_W +: V_W] = 25'd458752;
    for (int s = 0; s < 7; s++) begin
      run_step(s == 0, cur, 25'sd0, integ_exp[s], -1, s == 0);
    end

    // Inhibition dominates a zero input: potentials clamp at 0.
    cur = '0;
    run_step(1'b1, cur, 25'sd655360, 0, -1, 1'b0);
    run_step(1'b0, cur, 25'sd655360, 0, -1, 1'b0);

    // Maximum input on every neuron: all fire.
    for (int k = 0; k < N_NEURON; k++) cur[k*V_W +: V_W] = 25'h0FFFFFF;
    run_step(1'b1, cur, 25'sd0, 18, -1, 1'b0);

    // Sample boundary clears refractory state of neuron 5.
    cur = '0;
    cur[5*V_W +: V_W] = 25'd1310720;
    run_step(1'b1, cur, 25'sd0, 1, -1, 1'b0);
    run_step(1'b0, cur, 25'sd0, 0, -1, 1'b0);
    run_step(1'b1, cur, 25'sd0, 1, -1, 1'b0);

    // Mid-sweep reset must also clear refractory state of neuron 3.
    cur = '0;
    cur[3*V_W +: V_W] = 25'd1310720;
    run_step(1'b1, cur, 25'sd0, 1, -1, 1'b0);
    run_step(1'b0, cur, 25'sd0, 0, 9, 1'b0);
    run_step(1'b0, cur, 25'sd0, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
